ram_delay_dump: RTL and testbench



---
 rtl/ram_delay_pkg.sv | 21 ++
 rtl/ram_dp.sv | 30 +++
 rtl/ram_delay_dump.sv | 206 ++++++++++++++++++++
 tb/tb_ram_delay_dump.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_delay_pkg.sv
// Shared types and constants for the ram_delay capture/dump datapath.
package ram_delay_pkg;

  // Dump controller states: capture, issue reads, wait for the output to empty.
  typedef enum logic [1:0] {
    S_CAP   = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Default sample and address widths.
  localparam int DEF_NBITS_DATA = 14;
  localparam int DEF_NBITS_ADDR = 9;

  // Cycles from a RAM read strobe to its data appearing on rdata.
  localparam int RAM_RD_LAT = 1;

  // Number of words the output skid buffer can hold.
  localparam int OBUF_DEPTH = 2;

endpackage

// File: rtl/ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module ram_dp
  import ram_delay_pkg::*;
#(
  parameter int P_NBITS_DATA = DEF_NBITS_DATA,
  parameter int P_NBITS_ADDR = DEF_NBITS_ADDR
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [P_NBITS_ADDR-1:0] waddr,
  input  logic [P_NBITS_DATA-1:0] wdata,
  input  logic                    re,
  input  logic [P_NBITS_ADDR-1:0] raddr,
  output logic [P_NBITS_DATA-1:0] rdata
);

  logic [P_NBITS_DATA-1:0] mem [2**P_NBITS_ADDR];

  // Write on we; read data is registered and valid one cycle after re.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_delay_dump.sv
// Circular capture buffer: records the sample stream continuously and, on a
// trigger, freezes and replays the newest len samples oldest-first over a
// valid/ready stream. A small skid buffer absorbs downstream backpressure.
module ram_delay_dump
  import ram_delay_pkg::*;
#(
  parameter int P_NBITS_DATA = DEF_NBITS_DATA,
  parameter int P_NBITS_ADDR = DEF_NBITS_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_NBITS_ADDR-1:0] n,
  input  logic                    wr,
  input  logic [P_NBITS_DATA-1:0] d,
  input  logic                    trig,
  output logic                    busy,
  output logic [P_NBITS_DATA-1:0] q,
  output logic                    valid,
  input  logic                    ready,
  output logic                    last
);

  localparam int AW = P_NBITS_ADDR;
  localparam int DW = P_NBITS_DATA;
  localparam logic [AW-1:0] FILL_MAX = '1;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  // Controller state
  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   fill_q, fill_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic [AW-1:0]   rem_q, rem_d;
  logic            busy_q, busy_d;

  // Read pipeline tracking: which RAM reads are in flight and which is final
  logic [RAM_RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [RAM_RD_LAT-1:0] rd_last_q, rd_last_d;

  // Output skid buffer (two entries, head index plus occupancy count)
  logic [DW-1:0]   buf_data_q [OBUF_DEPTH];
  logic [DW-1:0]   buf_data_d [OBUF_DEPTH];
  logic            buf_last_q [OBUF_DEPTH];
  logic            buf_last_d [OBUF_DEPTH];
  logic            buf_head_q, buf_head_d;
  logic [1:0]      buf_cnt_q, buf_cnt_d;

  // Combinational helpers
  logic            wr_en;
  logic [AW-1:0]   wptr_nxt;
  logic [AW-1:0]   fill_nxt;
  logic [AW-1:0]   len;
  logic            trig_ok;
  logic            ram_vld;
  logic            ram_last;
  logic [DW-1:0]   ram_rdata;
  logic            buf_nempty;
  logic [DW-1:0]   head_data;
  logic            head_last;
  logic            out_valid;
  logic            pop;
  logic            push;
  logic            last_xfer;
  logic            issue;
  int              occ;

  ram_dp #(
    .P_NBITS_DATA (DW),
    .P_NBITS_ADDR (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (d),
    .re    (issue),
    .raddr (raddr_q),
    .rdata (ram_rdata)
  );

  // Capture-side view including a same-cycle write, so a sample arriving with
  // the trigger is stored and becomes the newest word of the dump.
  always_comb begin
    wr_en    = (state_q == S_CAP) && wr;
    wptr_nxt = wr_en ? (wptr_q + ADDR_ONE) : wptr_q;
    fill_nxt = (wr_en && (fill_q != FILL_MAX)) ? (fill_q + ADDR_ONE) : fill_q;
    len      = (fill_nxt < n) ? fill_nxt : n;
    trig_ok  = (state_q == S_CAP) && trig && (len != '0);
  end

  // Output head comes from the skid buffer when it holds data, otherwise
  // straight from the RAM read register; reads are only issued while the
  // buffer plus in-flight reads leave room, so nothing is ever dropped.
  always_comb begin
    ram_vld    = rd_vld_q[RAM_RD_LAT-1];
    ram_last   = rd_last_q[RAM_RD_LAT-1];
    buf_nempty = (buf_cnt_q != 2'd0);
    head_data  = '0;
    head_last  = 1'b0;
    if (buf_nempty) begin
      head_data = buf_data_q[buf_head_q];
      head_last = buf_last_q[buf_head_q];
    end else if (ram_vld) begin
      head_data = ram_rdata;
      head_last = ram_last;
    end
    out_valid = buf_nempty || ram_vld;
    pop       = out_valid && ready;
    last_xfer = pop && head_last;
    push      = ram_vld && !(pop && !buf_nempty);
    occ       = int'(buf_cnt_q) + $countones(rd_vld_q) - (pop ? 1 : 0);
    issue     = (state_q == S_READ) && (occ < OBUF_DEPTH);
  end

  assign q     = head_data;
  assign valid = out_valid;
  assign last  = head_last;
  assign busy  = busy_q;

  // Next-state logic for the controller, pointers and skid buffer.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_nxt;
    fill_d     = fill_nxt;
    raddr_d    = raddr_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    rd_vld_d   = RAM_RD_LAT'({rd_vld_q, issue});
    rd_last_d  = RAM_RD_LAT'({rd_last_q, issue && (rem_q == ADDR_ONE)});
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    buf_head_d = buf_head_q;
    buf_cnt_d  = buf_cnt_q;

    if (pop && buf_nempty) begin
      buf_head_d = ~buf_head_q;
      buf_cnt_d  = buf_cnt_q - 2'd1;
    end
    if (push) begin
      buf_data_d[buf_head_q ^ buf_cnt_q[0]] = ram_rdata;
      buf_last_d[buf_head_q ^ buf_cnt_q[0]] = ram_last;
      buf_cnt_d = buf_cnt_d + 2'd1;
    end

    unique case (state_q)
      S_CAP: begin
        if (trig_ok) begin
          raddr_d = wptr_nxt - len;
          rem_d   = len;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          raddr_d = raddr_q + ADDR_ONE;
          rem_d   = rem_q - ADDR_ONE;
          if (rem_q == ADDR_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (last_xfer) begin
          busy_d  = 1'b0;
          fill_d  = '0;
          state_d = S_CAP;
        end
      end
      default: state_d = S_CAP;
    endcase
  end

  // State register; reset abandons any dump in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_CAP;
      wptr_q     <= '0;
      fill_q     <= '0;
      raddr_q    <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      rd_vld_q   <= '0;
      rd_last_q  <= '0;
      buf_head_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
      raddr_q    <= raddr_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      buf_head_q <= buf_head_d;
      buf_cnt_q  <= buf_cnt_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
    end
  end

endmodule

// File: tb/tb_ram_delay_dump.sv
// Directed bench for ram_delay_dump: a history model of accepted writes
// produces the expected dump words into a scoreboard queue at trigger time,
// and every output transfer pops and compares against it.
module tb_ram_delay_dump;

  localparam int DW  = 14;
  localparam int AW  = 9;
  localparam int AWS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] n;
  logic          wr;
  logic [DW-1:0] d;
  logic          trig;
  logic          ready;

  logic          busy_b, valid_b, last_b;
  logic [DW-1:0] q_b;
  logic          busy_s, valid_s, last_s;
  logic [DW-1:0] q_s;

  logic          obs_busy, obs_valid, obs_last;
  logic [DW-1:0] obs_q;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t      sb[$];
  int        hist[$];
  bit        m_busy = 1'b0;
  bit        sel = 1'b0;
  bit        bp_mode = 1'b0;
  bit        prev_stall = 1'b0;
  logic [DW-1:0] prev_q;
  logic      prev_last;
  int        checks = 0;
  int        failures = 0;
  int        cyc = 0;
  int        popped = 0;
  int        trig_cyc = -1;
  int        first_valid_cyc = -1;

  always #5 clk = ~clk;

  ram_delay_dump #(.P_NBITS_DATA(DW), .P_NBITS_ADDR(AW)) dut (
    .clk(clk), .rst(rst), .n(n), .wr(wr), .d(d), .trig(trig),
    .busy(busy_b), .q(q_b), .valid(valid_b), .ready(ready), .last(last_b)
  );

  ram_delay_dump #(.P_NBITS_DATA(DW), .P_NBITS_ADDR(AWS)) dut_wrap (
    .clk(clk), .rst(rst), .n(n[AWS-1:0]), .wr(wr), .d(d), .trig(trig),
    .busy(busy_s), .q(q_s), .valid(valid_s), .ready(ready), .last(last_s)
  );

  assign obs_busy  = sel ? busy_s  : busy_b;
  assign obs_valid = sel ? valid_s : valid_b;
  assign obs_last  = sel ? last_s  : last_b;
  assign obs_q     = sel ? q_s     : q_b;

  // Watchdog so a stuck DUT can never hang the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    hist.delete();
    m_busy     = 1'b0;
    prev_stall = 1'b0;
  endtask

  // One clock cycle: sample at the falling edge, update the model, compare.
  task automatic tick();
    exp_t e;
    int   len;
    int   maxlen;
    int   n_eff;
    @(negedge clk);
    cyc++;
    check_output("busy", obs_busy, m_busy);
    if (prev_stall) begin
      check_output("stall_valid", obs_valid, 1);
      check_output("stall_q", obs_q, prev_q);
      check_output("stall_last", obs_last, prev_last);
    end
    maxlen = sel ? (2**AWS - 1) : (2**AW - 1);
    n_eff  = sel ? int'(n[AWS-1:0]) : int'(n);
    if (!m_busy && wr) hist.push_back(int'(d));
    if (!m_busy && trig) begin
      len = hist.size();
      if (len > maxlen) len = maxlen;
      if (len > n_eff) len = n_eff;
      if (len != 0) begin
        for (int i = hist.size() - len; i < hist.size(); i++) begin
          e.data = DW'(hist[i]);
          e.last = (i == hist.size() - 1);
          sb.push_back(e);
        end
        m_busy          = 1'b1;
        trig_cyc        = cyc;
        first_valid_cyc = -1;
      end
    end
    if (obs_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      check_output("spurious_valid", obs_valid, sb.size() != 0);
      if (ready && sb.size() != 0) begin
        e = sb.pop_front();
        check_output("dump_q", obs_q, e.data);
        check_output("dump_last", obs_last, e.last);
        popped++;
        if (e.last) begin
          m_busy = 1'b0;
          hist.delete();
        end
      end
    end else begin
      check_output("last_idle", obs_last, 0);
    end
    prev_stall = obs_valid && !ready;
    prev_q     = obs_q;
    prev_last  = obs_last;
    @(posedge clk);
    #1;
    if (bp_mode) ready = (cyc % 4 == 0) || (cyc % 4 == 3);
  endtask

  task automatic apply_stimulus(input logic wr_i, input int d_i, input logic trig_i);
    wr   = wr_i;
    d    = DW'(d_i);
    trig = trig_i;
    tick();
    wr   = 1'b0;
    trig = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !m_busy) break;
      tick();
    end
    check_output("drain_left", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    wr    = 1'b0;
    trig  = 1'b0;
    ready = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    rst   = 1'b0;
    n     = '0;
    wr    = 1'b0;
    d     = '0;
    trig  = 1'b0;
    ready = 1'b1;
    #2;
    check_output("reset_q", obs_q, 0);
    check_output("reset_valid", obs_valid, 0);
    check_output("reset_busy", obs_busy, 0);
    check_output("reset_last", obs_last, 0);
    do_reset();

    $display("[TB] basic dump");
    n  = AW'(16);
    p0 = popped;
    for (int i = 0; i < 39; i++) apply_stimulus(1'b1, i, 1'b0);
    apply_stimulus(1'b1, 39, 1'b1);
    run_until_idle(100);
    check_output("basic_latency", first_valid_cyc - trig_cyc, 2);
    check_output("basic_count", popped - p0, 16);

    $display("[TB] partial window");
    do_reset();
    n  = AW'(16);
    p0 = popped;
    for (int i = 100; i <= 104; i++) apply_stimulus(1'b1, i, 1'b0);
    apply_stimulus(1'b0, 0, 1'b1);
    run_until_idle(100);
    check_output("partial_count", popped - p0, 5);

    $display("[TB] backpressure");
    do_reset();
    n       = AW'(16);
    p0      = popped;
    bp_mode = 1'b1;
    for (int i = 0; i < 39; i++) apply_stimulus(1'b1, i, 1'b0);
    apply_stimulus(1'b1, 39, 1'b1);
    run_until_idle(200);
    bp_mode = 1'b0;
    ready   = 1'b1;
    check_output("bp_count", popped - p0, 16);

    $display("[TB] ignored events during dump");
    do_reset();
    n  = AW'(16);
    p0 = popped;
    for (int i = 0; i < 39; i++) apply_stimulus(1'b1, i, 1'b0);
    apply_stimulus(1'b1, 39, 1'b1);
    n = AW'(3);
    for (int k = 0; k < 10; k++) apply_stimulus(1'b1, 999, (k % 3) == 0);
    n = AW'(16);
    run_until_idle(100);
    check_output("ign_first_count", popped - p0, 16);
    p0 = popped;
    for (int i = 200; i <= 215; i++) apply_stimulus(1'b1, i, 1'b0);
    apply_stimulus(1'b0, 0, 1'b1);
    run_until_idle(100);
    check_output("ign_second_count", popped - p0, 16);

    $display("[TB] wrap-around on 16-deep instance");
    do_reset();
    sel = 1'b1;
    n   = AW'(15);
    p0  = popped;
    for (int i = 0; i < 49; i++) apply_stimulus(1'b1, i, 1'b0);
    apply_stimulus(1'b1, 49, 1'b1);
    run_until_idle(100);
    check_output("wrap_latency", first_valid_cyc - trig_cyc, 2);
    check_output("wrap_count", popped - p0, 15);
    sel = 1'b0;

    $display("[TB] reset mid-dump");
    do_reset();
    n  = AW'(16);
    p0 = popped;
    for (int i = 0; i < 39; i++) apply_stimulus(1'b1, i, 1'b0);
    apply_stimulus(1'b1, 39, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (popped - p0 >= 3) break;
      tick();
    end
    check_output("mid_words", popped - p0, 3);
    rst = 1'b0;
    #1;
    check_output("mid_rst_valid", obs_valid, 0);
    check_output("mid_rst_busy", obs_busy, 0);
    check_output("mid_rst_last", obs_last, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 0, 1'b1);
    repeat (4) tick();
    check_output("post_rst_busy", obs_busy, 0);
    check_output("post_rst_valid", obs_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
